// File: rtl/miriscv_radix2_divider_pkg.sv
// miriscv_radix2_divider_pkg
// Shared constants and types for the radix-2 divider slice. This package
// holds the operand width, the MDU opcode encodings (RISC-V funct3 values),
// the divider FSM state type and the iteration counter width.
package miriscv_radix2_divider_pkg;

    localparam int XLEN      = 32;
    localparam int MDU_OP_W  = 3;
    localparam int DIV_CNT_W = $clog2(XLEN);

    localparam logic [MDU_OP_W-1:0] MDU_DIV  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_REM  = 3'd6;
    localparam logic [MDU_OP_W-1:0] MDU_REMU = 3'd7;

    // Most negative signed value; dividing it by -1 is the overflow case.
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_e;

    function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/miriscv_radix2_divider_if.sv
// miriscv_radix2_divider_if
// Connection between the multiply/divide unit (master) and the divider
// (slave): start/kill/keep controls, operands, opcode, the registered
// divisor-zero flag, both results and the stall request.
interface miriscv_radix2_divider_if;
    import miriscv_radix2_divider_pkg::*;

    logic                div_start_i;
    logic [XLEN-1:0]     port_a_i;
    logic [XLEN-1:0]     port_b_i;
    logic [MDU_OP_W-1:0] mdu_op_i;
    logic                zero_i;
    logic                kill_i;
    logic                keep_i;
    logic [XLEN-1:0]     div_result_o;
    logic [XLEN-1:0]     rem_result_o;
    logic                div_stall_req_o;

    modport master (
        output div_start_i, port_a_i, port_b_i, mdu_op_i, zero_i, kill_i, keep_i,
        input  div_result_o, rem_result_o, div_stall_req_o
    );

    modport slave (
        input  div_start_i, port_a_i, port_b_i, mdu_op_i, zero_i, kill_i, keep_i,
        output div_result_o, rem_result_o, div_stall_req_o
    );

endinterface

// File: rtl/miriscv_radix2_divider_div_step.sv
// miriscv_div_step
// One combinational restoring-division step.
//   rem_i          partial remainder (always < divisor)
//   divisor_i      divisor magnitude
//   dividend_bit_i next dividend bit, MSB first
//   rem_o          next partial remainder
//   q_bit_o        quotient bit produced by this step
module miriscv_div_step
    import miriscv_radix2_divider_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            dividend_bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, dividend_bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // With shifted[XLEN] clear both operands are below 2^XLEN, so diff[XLEN]
    // is a true sign bit. With it set the shifted value already exceeds any
    // divisor and the subtraction always succeeds.
    assign q_bit_o = shifted[XLEN] | ~diff[XLEN];
    assign rem_o   = q_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/miriscv_radix2_divider.sv
// miriscv_radix2_divider
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU. Produces one
// quotient bit per cycle on magnitudes and fixes the signs at the end.
// Ports:
//   clk_i   clock
//   arst_i  asynchronous active-high reset
//   div_if  slave side of miriscv_radix2_divider_if (controls, operands,
//           quotient/remainder results, combinational stall request)
module miriscv_radix2_divider
    import miriscv_radix2_divider_pkg::*;
(
    input logic                    clk_i,
    input logic                    arst_i,
    miriscv_radix2_divider_if.slave div_if
);

    div_state_e           state_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]      dividend_q;   // shifts dividend out, quotient in
    logic [XLEN-1:0]      divisor_q;
    logic [XLEN-1:0]      rem_q;
    logic                 signed_q;
    logic                 q_neg_q;
    logic                 r_neg_q;
    logic [XLEN-1:0]      div_result_q;
    logic [XLEN-1:0]      rem_result_q;

    logic            op_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            accept;
    logic            busy;
    logic [XLEN-1:0] step_rem;
    logic            step_q_bit;

    assign op_signed = is_signed_op(div_if.mdu_op_i);
    assign sign_a    = op_signed & div_if.port_a_i[XLEN-1];
    assign sign_b    = op_signed & div_if.port_b_i[XLEN-1];
    assign abs_a     = sign_a ? -div_if.port_a_i : div_if.port_a_i;
    assign abs_b     = sign_b ? -div_if.port_b_i : div_if.port_b_i;

    // A new operation is taken from IDLE, or from DONE unless the pipeline
    // asks to keep the held result.
    assign accept = div_if.div_start_i & ~div_if.kill_i &
                    ((state_q == IDLE) | ((state_q == DONE) & ~div_if.keep_i));
    assign busy   = state_q inside {PREP, CALC, FIX};

    assign div_if.div_stall_req_o = accept | (busy & ~div_if.kill_i);
    assign div_if.div_result_o    = div_result_q;
    assign div_if.rem_result_o    = rem_result_q;

    miriscv_div_step u_div_step (
        .rem_i          (rem_q),
        .divisor_i      (divisor_q),
        .dividend_bit_i (dividend_q[XLEN-1]),
        .rem_o          (step_rem),
        .q_bit_o        (step_q_bit)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            signed_q     <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            div_result_q <= '0;
            rem_result_q <= '0;
        end else if (div_if.kill_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q    <= PREP;
                        signed_q   <= op_signed;
                        dividend_q <= abs_a;
                        divisor_q  <= abs_b;
                        q_neg_q    <= sign_a ^ sign_b;
                        r_neg_q    <= sign_a;
                    end else if ((state_q == DONE) && div_if.div_start_i && div_if.keep_i) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PREP: begin
                    // zero_i arrives one cycle after the operands, so the
                    // special cases are resolved here rather than in IDLE.
                    if (div_if.zero_i) begin
                        div_result_q <= '1;
                        rem_result_q <= div_if.port_a_i;
                        state_q      <= DONE;
                    end else if (signed_q && (div_if.port_a_i == XLEN_MIN) &&
                                 (div_if.port_b_i == '1)) begin
                        div_result_q <= XLEN_MIN;
                        rem_result_q <= '0;
                        state_q      <= DONE;
                    end else begin
                        rem_q   <= '0;
                        cnt_q   <= DIV_CNT_W'(XLEN - 1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q      <= step_rem;
                    dividend_q <= {dividend_q[XLEN-2:0], step_q_bit};
                    cnt_q      <= cnt_q - DIV_CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    div_result_q <= q_neg_q ? -dividend_q : dividend_q;
                    rem_result_q <= r_neg_q ? -rem_q : rem_q;
                    state_q      <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_radix2_divider.sv
// tb_miriscv_radix2_divider
// Drives directed and random divisions through the divider and compares
// stall and results every cycle against an arithmetic reference model.
module tb_miriscv_radix2_divider;
    import miriscv_radix2_divider_pkg::*;

    logic clk  = 1'b0;
    logic arst = 1'b1;

    miriscv_radix2_divider_if bus();

    miriscv_radix2_divider dut (
        .clk_i  (clk),
        .arst_i (arst),
        .div_if (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        exp_stall = 1'b0;
    logic [31:0] exp_div   = '0;
    logic [31:0] exp_rem   = '0;
    bit          checking  = 1'b0;

    // Reference: RISC-V division semantics in plain arithmetic.
    // lat is the stall length in cycles.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        bit sgn;
        int sa, sb;
        sgn = (op == MDU_DIV) || (op == MDU_REM);
        sa  = a;
        sb  = b;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 2;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0; lat = 2;
        end else if (sgn) begin
            q = sa / sb; r = sa % sb; lat = 35;
        end else begin
            q = a / b; r = a % b; lat = 35;
        end
    endtask

    task automatic pin(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                       input int elat);
        logic [31:0] q, r;
        int lat;
        model(op, a, b, q, r, lat);
        total++;
        if (q !== eq || r !== er || lat != elat) begin
            bad++;
            $display("FAIL model_%s got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                     name, q, r, lat, eq, er, elat);
        end
    endtask

    // Single compare process: every cycle, mid-cycle.
    always @(negedge clk) begin
        if (checking) begin
            total++;
            if (bus.div_stall_req_o !== exp_stall) begin
                bad++;
                $display("FAIL stall t=%0t got=%b want=%b", $time, bus.div_stall_req_o, exp_stall);
            end
            total++;
            if (bus.div_result_o !== exp_div) begin
                bad++;
                $display("FAIL div_result t=%0t got=%h want=%h", $time, bus.div_result_o, exp_div);
            end
            total++;
            if (bus.rem_result_o !== exp_rem) begin
                bad++;
                $display("FAIL rem_result t=%0t got=%h want=%h", $time, bus.rem_result_o, exp_rem);
            end
        end
    end

    // abort_kind: 1 = kill_i, 2 = asynchronous reset; applied abort_at cycles after T.
    task automatic apply_abort(input int kind);
        if (kind == 1) begin
            bus.kill_i = 1'b1;
        end else begin
            arst            = 1'b1;
            bus.div_start_i = 1'b0;
            exp_div         = '0;
            exp_rem         = '0;
        end
        exp_stall = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int abort_at, input int abort_kind, input bit hold_done);
        logic [31:0] q, r;
        int lat;
        model(op, a, b, q, r, lat);
        $display("op=%0d a=%h b=%h -> q=%h r=%h lat=%0d abort_at=%0d kind=%0d",
                 op, a, b, q, r, lat, abort_at, abort_kind);
        @(posedge clk); #1;
        // zero_i keeps its stale value here: it is registered upstream.
        bus.div_start_i = 1'b1;
        bus.keep_i      = 1'b0;
        bus.kill_i      = 1'b0;
        bus.port_a_i    = a;
        bus.port_b_i    = b;
        bus.mdu_op_i    = op;
        exp_stall       = 1'b1;
        if (abort_at == 0) apply_abort(abort_kind);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            bus.div_start_i = 1'b0;
            bus.zero_i      = (b == 0);
            if (bus.kill_i || arst) begin
                // Cycle after an abort: FSM must be idle (no stall, results held).
                bus.kill_i = 1'b0;
                arst       = 1'b0;
                exp_stall  = 1'b0;
                return;
            end
            if (i == abort_at) begin
                apply_abort(abort_kind);
            end else if (i < lat) begin
                exp_stall = 1'b1;
            end else begin
                exp_stall = 1'b0;
                exp_div   = q;
                exp_rem   = r;
                if (hold_done) begin
                    bus.div_start_i = 1'b1;
                    bus.keep_i      = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int sel;

        bus.div_start_i = 1'b0;
        bus.port_a_i    = '0;
        bus.port_b_i    = '0;
        bus.mdu_op_i    = MDU_DIVU;
        bus.zero_i      = 1'b0;
        bus.kill_i      = 1'b0;
        bus.keep_i      = 1'b0;
        checking        = 1'b1;

        // Hand-computed values pinning the model.
        pin("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 35);
        pin("div_m7_2",   MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35);
        pin("rem_7_m2",   MDU_REM,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 35);
        pin("divu_5_0",   MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2);
        pin("div_ovf",    MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2);
        pin("divu_big",   MDU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 35);

        // Reset state observed for two cycles.
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;

        do_op(MDU_DIVU, 32'd100, 32'd7, -1, 0, 1'b0);
        do_op(MDU_DIV,  32'hFFFF_FFF9, 32'd2, -1, 0, 1'b0);
        do_op(MDU_REM,  32'hFFFF_FFF9, 32'd2, -1, 0, 1'b0);
        do_op(MDU_DIVU, 32'd5, 32'd0, -1, 0, 1'b0);
        do_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 1'b0);
        do_op(MDU_REMU, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 1'b0);

        // Kill mid-calculation, then a clean DIVU 9/4.
        do_op(MDU_DIVU, 32'd123456, 32'd789, 10, 1, 1'b0);
        do_op(MDU_DIVU, 32'd9, 32'd4, -1, 0, 1'b0);
        // Kill coinciding with start: nothing accepted.
        do_op(MDU_DIV, 32'd50, 32'd3, 0, 1, 1'b0);

        // Keep: held in DONE for 5 cycles, then a new op started from DONE.
        do_op(MDU_DIVU, 32'd1000, 32'd33, -1, 0, 1'b1);
        repeat (4) @(posedge clk);
        do_op(MDU_REMU, 32'd1000, 32'd33, -1, 0, 1'b0);

        // Asynchronous reset during CALC, then DIVU 0xFFFFFFFF/1.
        do_op(MDU_DIVU, 32'd77, 32'd3, 8, 2, 1'b0);
        do_op(MDU_DIVU, 32'hFFFF_FFFF, 32'd1, -1, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op  = 3'(4 + $urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 100);
                4: b = -($urandom_range(1, 9));
                default: ;
            endcase
            do_op(op, a, b, -1, 0, 1'b0);
        end

        @(posedge clk);
        @(posedge clk);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/miriscv_radix2_divider.md
# miriscv_radix2_divider

Iterative restoring radix-2 integer divider for the MIRISCV M-extension. It sits directly under the multiply/divide unit, which drives it with operands, opcode, a registered divisor-zero flag and pipeline kill/keep controls. It returns quotient and remainder together and holds the pipeline with a stall request while computing. It covers DIV, DIVU, REM and REMU, including the RISC-V divide-by-zero and signed-overflow results.

## Interface
Parameters:
- XLEN, 32, operand/result width (from miriscv_pkg)
- MDU_OP_W, from miriscv_mdu_pkg, opcode width

Ports:
- clk_i  in  1  clock; only clock in the block
- arst_i  in  1  reset; asynchronous, active-high
- div_start_i  in  1  request a division this cycle
- port_a_i  in  XLEN  dividend; stable while div_stall_req_o=1
- port_b_i  in  XLEN  divisor; stable while div_stall_req_o=1
- mdu_op_i  in  MDU_OP_W  MDU_DIV/MDU_DIVU/MDU_REM/MDU_REMU
- zero_i  in  1  port_b_i==0, registered upstream (one cycle late)
- kill_i  in  1  abort current operation
- keep_i  in  1  reuse held result; do not recompute
- div_result_o  out  XLEN  quotient
- rem_result_o  out  XLEN  remainder
- div_stall_req_o  out  1  pipeline stall while result not ready

## Operation
- Signed ops: MDU_DIV and MDU_REM. Unsigned ops: MDU_DIVU and MDU_REMU. Both outputs are always computed; the MDU selects which to use.
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if div_start_i and not kill_i, go to PREP.
  - Latch the signed flag.
  - Latch |a| and |b|; raw values when unsigned.
  - Latch quotient sign = sa^sb and remainder sign = sa.
- PREP: zero_i is now valid.
  - If zero_i: quotient=all-ones, remainder=port_a_i, go to DONE.
  - Else if signed, a=0x8000_0000 and b=all-ones: quotient=0x8000_0000, remainder=0, go to DONE.
  - Else: clear the partial remainder, load the iteration counter with XLEN-1, go to CALC.
- CALC: one quotient bit per cycle, MSB first.
  - Shift the partial remainder left by 1, bringing in the next dividend bit.
  - Trial-subtract the divisor using an XLEN+1-bit subtractor.
  - If the difference is non-negative, keep it and set the quotient bit to 1.
  - Go to FIX when the counter reaches 0.
- FIX: negate the quotient if the quotient sign is set. Negate the remainder if the remainder sign is set. Go to DONE.
- DONE: results are valid.
  - div_start_i and keep_i: stay in DONE with no recompute.
  - div_start_i and not keep_i: behave as IDLE, accepting a new operation.
  - Otherwise: go to IDLE.
- Output registers hold their value until the next fast-path or FIX write.
- kill_i in any state forces IDLE on the next edge and overrides div_start_i. Result registers are left unchanged.
- Reset, including mid-operation: state IDLE, div_result_o=0, rem_result_o=0, div_stall_req_o=0, counter and datapath cleared.

## Timing
- T denotes the cycle in which the start is accepted.
- Normal path:
  - T: IDLE, start accepted.
  - T+1: PREP.
  - T+2..T+XLEN+1: CALC.
  - T+XLEN+2: FIX.
  - T+XLEN+3: DONE.
- Fast path (zero or overflow): PREP at T+1, DONE at T+2.
- div_stall_req_o is combinational. It equals 1 when div_start_i=1 in IDLE, or in DONE with keep_i=0, or in state PREP, CALC or FIX. In all cases it is forced to 0 when kill_i=1.
- Stall length: XLEN+3 cycles on the normal path (35 for XLEN=32); 2 cycles on the fast path.
- In DONE, div_stall_req_o=0 and outputs are valid in that same cycle.
- After the stall drops, upstream may change operands freely.

## Structure
- Add typedef enum div_state_e {IDLE, PREP, CALC, FIX, DONE} to miriscv_mdu_pkg.
- Reuse the existing MDU_* opcode constants from that package.
- Counter width is $clog2(XLEN); add it as a package localparam.
- One combinational sub-module, miriscv_div_step. Inputs: partial remainder, divisor, next dividend bit. Outputs: next remainder and quotient bit. Instantiate it once.

## Test plan
- DIVU 100/7 -> stall held 35 cycles; in DONE div_result_o=14, rem_result_o=2.
- DIV -7/2 (0xFFFF_FFF9, 2) -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF; REM gives the same rem_result_o.
- DIVU 5/0 -> stall 2 cycles; quotient 0xFFFF_FFFF, remainder 5. DIV 0x8000_0000/0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0, stall 2 cycles.
- kill_i at T+10 -> stall 0 that cycle, IDLE next; a following DIVU 9/4 gives 2 rem 1 with full 35-cycle latency.
- After DONE, hold div_start_i=1 with keep_i=1 for 5 cycles -> stall stays 0, outputs unchanged, FSM stays in DONE. Drop keep_i -> a new 35-cycle stall begins.
- Assert arst_i during CALC -> all outputs 0 immediately and FSM in IDLE. After release, DIVU 0xFFFF_FFFF/1 -> quotient 0xFFFF_FFFF, remainder 0.
